// File: rtl/stdp_pkg.sv
// Purpose: shared helpers for the STDP trace array (clog2, weight clamp, trace decay).
// Latency: n/a (pure functions).
// Backpressure: n/a.
package stdp_pkg;

   // Ceiling log2, used to size the synapse select ports.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Saturate a signed update result into the unsigned weight range [0, 2**width-1].
   function automatic int clamp_weight(input int v, input int width);
      int w_max;
      w_max = (1 << width) - 1;
      if (v < 0) return 0;
      if (v > w_max) return w_max;
      return v;
   endfunction

   // One decay tick: subtract t>>shift. Once that term reaches zero, fall back to a
   // unit step so the trace still reaches 0 instead of stalling at a small residue.
   function automatic int trace_decay(input int t, input int shift);
      int d;
      d = t >> shift;
      if (d != 0) return t - d;
      if (t != 0) return t - 1;
      return 0;
   endfunction

endpackage

// File: rtl/stdp_trace.sv
// Purpose: one eligibility trace register; a spike sets it to full scale, a tick decays it.
// Latency: 1 cycle from spike/tick to the new trace value.
// Backpressure: none; spike and tick are accepted every cycle, spike wins over tick.
//  Ports: clk, rst_n, spike (set to max), tick (decay strobe), trace (current value).
module stdp_trace
   import stdp_pkg::*;
#(
   parameter int T_WIDTH     = 8,
   parameter int DECAY_SHIFT = 2
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               spike,
   input  logic               tick,
   output logic [T_WIDTH-1:0] trace
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trace <= '0;
      end else if (spike) begin
         trace <= '1;
      end else if (tick) begin
         trace <= T_WIDTH'(trace_decay(int'(trace), DECAY_SHIFT));
      end
   end

endmodule

// File: rtl/stdp_trace_array.sv
// Purpose: trace-based STDP engine, N_PRE presynaptic inputs onto one postsynaptic neuron,
//          with per-synapse saturating weights and host weight load/readout.
// Latency: 1 cycle from spike to weight change / upd_valid; rd_weight is combinational.
// Backpressure: none; every input is sampled every cycle.
//  Ports: pre_spike/post_spike/tick drive traces; learn_en gates weight learning;
//         wr_en/wr_sel/wr_data host write; rd_sel -> rd_weight; weights = all weights flat;
//         upd_valid pulses when learning changed at least one weight.
module stdp_trace_array
   import stdp_pkg::*;
#(
   parameter int  N_PRE       = 4,
   parameter int  W_WIDTH     = 8,
   parameter int  T_WIDTH     = 8,
   parameter int  DECAY_SHIFT = 2,
   parameter int  LTP_SHIFT   = 3,
   parameter int  LTD_SHIFT   = 3,
   parameter int  W_INIT      = 128,
   localparam int SEL_W       = clog2(N_PRE)
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_PRE-1:0]         pre_spike,
   input  logic                     post_spike,
   input  logic                     tick,
   input  logic                     learn_en,
   input  logic                     wr_en,
   input  logic [SEL_W-1:0]         wr_sel,
   input  logic [W_WIDTH-1:0]       wr_data,
   input  logic [SEL_W-1:0]         rd_sel,
   output logic [W_WIDTH-1:0]       rd_weight,
   output logic [N_PRE*W_WIDTH-1:0] weights,
   output logic                     upd_valid
);

   logic [T_WIDTH-1:0]        pre_trace [N_PRE];
   logic [T_WIDTH-1:0]        post_trace;
   logic [W_WIDTH-1:0]        w         [N_PRE];
   logic [W_WIDTH-1:0]        w_learn   [N_PRE];
   logic signed [W_WIDTH+1:0] w_sum     [N_PRE];
   logic [N_PRE-1:0]          wr_hit;
   logic [N_PRE-1:0]          changed;

   // Traces: index N_PRE is the postsynaptic trace, the rest are presynaptic.
   for (genvar g = 0; g <= N_PRE; g++) begin : g_trace
      if (g < N_PRE) begin : g_pre
         stdp_trace #(.T_WIDTH(T_WIDTH), .DECAY_SHIFT(DECAY_SHIFT)) u_trace (
            .clk   (clk),
            .rst_n (rst_n),
            .spike (pre_spike[g]),
            .tick  (tick),
            .trace (pre_trace[g])
         );
      end else begin : g_post
         stdp_trace #(.T_WIDTH(T_WIDTH), .DECAY_SHIFT(DECAY_SHIFT)) u_trace (
            .clk   (clk),
            .rst_n (rst_n),
            .spike (post_spike),
            .tick  (tick),
            .trace (post_trace)
         );
      end
   end

   // Learning uses the trace values registered before this edge, so a spike never
   // pairs with the other side's trace that it is setting in the same cycle.
   always_comb begin
      for (int i = 0; i < N_PRE; i++) begin
         w_sum[i] = $signed({2'b00, w[i]})
                  + (post_spike   ? $signed((W_WIDTH+2)'(pre_trace[i] >> LTP_SHIFT)) : '0)
                  - (pre_spike[i] ? $signed((W_WIDTH+2)'(post_trace   >> LTD_SHIFT)) : '0);
         w_learn[i] = W_WIDTH'(clamp_weight(int'(w_sum[i]), W_WIDTH));
         // Out-of-range wr_sel never matches any synapse, so such writes are dropped.
         wr_hit[i]  = wr_en && (wr_sel == SEL_W'(i));
         // A host write owns its synapse this cycle; a clamp that lands on the old
         // value is not a change.
         changed[i] = learn_en && !wr_hit[i] && (w_learn[i] != w[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PRE; i++) w[i] <= W_WIDTH'(W_INIT);
         upd_valid <= 1'b0;
      end else begin
         for (int i = 0; i < N_PRE; i++) begin
            if (wr_hit[i]) begin
               w[i] <= wr_data;
            end else if (learn_en) begin
               w[i] <= w_learn[i];
            end
         end
         upd_valid <= |changed;
      end
   end

   always_comb begin
      rd_weight = '0;
      for (int i = 0; i < N_PRE; i++) begin
         if (rd_sel == SEL_W'(i)) rd_weight = w[i];
      end
   end

   for (genvar g = 0; g < N_PRE; g++) begin : g_flat
      assign weights[g*W_WIDTH +: W_WIDTH] = w[g];
   end

endmodule

// File: tb/tb_stdp_trace_array.sv
// Purpose: directed self-checking bench for stdp_trace_array with default parameters.
// Latency: checks weights one cycle after each spike cycle.
// Backpressure: n/a.
module tb_stdp_trace_array;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] pre_spike;
   logic       post_spike;
   logic       tick;
   logic       learn_en;
   logic       wr_en;
   logic [1:0] wr_sel;
   logic [7:0] wr_data;
   logic [1:0] rd_sel;
   logic [7:0] rd_weight;
   logic [31:0] weights;
   logic       upd_valid;

   int total = 0;
   int bad   = 0;

   stdp_trace_array dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .tick       (tick),
      .learn_en   (learn_en),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_data    (wr_data),
      .rd_sel     (rd_sel),
      .rd_weight  (rd_weight),
      .weights    (weights),
      .upd_valid  (upd_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] wt(input int i);
      return weights[i*8 +: 8];
   endfunction

   // Advance one edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pre_spike  = '0;
      post_spike = 1'b0;
      tick       = 1'b0;
      wr_en      = 1'b0;
      wr_sel     = '0;
      wr_data    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      learn_en = 1'b1;
      rd_sel   = '0;
      rst_n    = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         total++;
         if (wt(i) !== 8'd128) begin
            bad++; $display("FAIL reset_w%0d got=%0d exp=128", i, wt(i));
         end
         total++;
         if (rd_weight !== 8'd128) begin
            bad++; $display("FAIL reset_rd%0d got=%0d exp=128", i, rd_weight);
         end
      end
      total++;
      if (upd_valid !== 1'b0) begin
         bad++; $display("FAIL reset_upd got=%b exp=0", upd_valid);
      end
   endtask

   task automatic test_ltp(input logic le, input logic [7:0] exp_w0, input logic exp_upd);
      logic [7:0] exp [4];
      do_reset();
      learn_en = le;
      pre_spike = 4'b0001; step(); idle_inputs();
      tick = 1'b1;         step(); idle_inputs();   // pre trace 255 -> 192
      post_spike = 1'b1;   step(); idle_inputs();   // +192>>3 = +24
      exp = '{exp_w0, 8'd128, 8'd128, 8'd128};
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wt(i) !== exp[i]) begin
            bad++; $display("FAIL ltp_le%0b_w%0d got=%0d exp=%0d", le, i, wt(i), exp[i]);
         end
      end
      total++;
      if (upd_valid !== exp_upd) begin
         bad++; $display("FAIL ltp_le%0b_upd got=%b exp=%b", le, upd_valid, exp_upd);
      end
      rd_sel = 2'd0; #1;
      total++;
      if (rd_weight !== exp_w0) begin
         bad++; $display("FAIL ltp_le%0b_rd got=%0d exp=%0d", le, rd_weight, exp_w0);
      end
      step();
      total++;
      if (upd_valid !== 1'b0) begin
         bad++; $display("FAIL ltp_le%0b_upd_pulse got=%b exp=0", le, upd_valid);
      end
   endtask

   task automatic test_ltd();
      logic [7:0] exp [4];
      do_reset();
      post_spike = 1'b1;   step(); idle_inputs();
      tick = 1'b1;         step();                  // 255 -> 192
                           step(); idle_inputs();   // 192 -> 144
      pre_spike = 4'b0010; step(); idle_inputs();   // -144>>3 = -18
      exp = '{8'd128, 8'd110, 8'd128, 8'd128};
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wt(i) !== exp[i]) begin
            bad++; $display("FAIL ltd_w%0d got=%0d exp=%0d", i, wt(i), exp[i]);
         end
      end
      total++;
      if (upd_valid !== 1'b1) begin
         bad++; $display("FAIL ltd_upd got=%b exp=1", upd_valid);
      end
   endtask

   task automatic test_sat_hi();
      do_reset();
      wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'd250; step(); idle_inputs();
      total++;
      if (upd_valid !== 1'b0) begin
         bad++; $display("FAIL sat_hi_wr_upd got=%b exp=0", upd_valid);
      end
      pre_spike = 4'b0100; step(); idle_inputs();
      post_spike = 1'b1;   step(); idle_inputs();   // 250 + 31 clamps to 255
      total++;
      if (wt(2) !== 8'd255) begin
         bad++; $display("FAIL sat_hi_w2 got=%0d exp=255", wt(2));
      end
      total++;
      if (upd_valid !== 1'b1) begin
         bad++; $display("FAIL sat_hi_upd got=%b exp=1", upd_valid);
      end
      // Already at the ceiling: another LTP clamps to the same value, no update pulse.
      post_spike = 1'b1; step(); idle_inputs();
      total++;
      if (wt(2) !== 8'd255 || upd_valid !== 1'b0) begin
         bad++; $display("FAIL sat_hi_hold got_w=%0d got_upd=%b exp_w=255 exp_upd=0", wt(2), upd_valid);
      end
   endtask

   task automatic test_sat_lo();
      do_reset();
      wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'd5; step(); idle_inputs();
      post_spike = 1'b1;   step(); idle_inputs();
      pre_spike = 4'b1000; step(); idle_inputs();   // 5 - 31 clamps to 0
      total++;
      if (wt(3) !== 8'd0) begin
         bad++; $display("FAIL sat_lo_w3 got=%0d exp=0", wt(3));
      end
      total++;
      if (upd_valid !== 1'b1) begin
         bad++; $display("FAIL sat_lo_upd got=%b exp=1", upd_valid);
      end
   endtask

   task automatic test_coincide();
      do_reset();
      pre_spike = 4'b0001; post_spike = 1'b1; step(); idle_inputs();
      total++;
      if (wt(0) !== 8'd128) begin
         bad++; $display("FAIL coincide_w0 got=%0d exp=128", wt(0));
      end
      total++;
      if (upd_valid !== 1'b0) begin
         bad++; $display("FAIL coincide_upd got=%b exp=0", upd_valid);
      end
   endtask

   task automatic test_decay_floor();
      do_reset();
      pre_spike = 4'b0001; step(); idle_inputs();
      tick = 1'b1;
      for (int k = 0; k < 40; k++) step();
      idle_inputs();
      post_spike = 1'b1; step(); idle_inputs();
      total++;
      if (wt(0) !== 8'd128 || upd_valid !== 1'b0) begin
         bad++; $display("FAIL decay_floor got_w=%0d got_upd=%b exp_w=128 exp_upd=0", wt(0), upd_valid);
      end
   endtask

   task automatic test_spike_tick();
      do_reset();
      pre_spike = 4'b0001; tick = 1'b1; step(); idle_inputs();  // spike wins: 255
      post_spike = 1'b1; step(); idle_inputs();                 // +31
      total++;
      if (wt(0) !== 8'd159) begin
         bad++; $display("FAIL spike_tick_w0 got=%0d exp=159", wt(0));
      end
   endtask

   task automatic test_write_vs_learn();
      do_reset();
      pre_spike = 4'b0011; step(); idle_inputs();
      post_spike = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'd77; step(); idle_inputs();
      total++;
      if (wt(0) !== 8'd77) begin
         bad++; $display("FAIL wr_vs_learn_w0 got=%0d exp=77", wt(0));
      end
      total++;
      if (wt(1) !== 8'd159) begin
         bad++; $display("FAIL wr_vs_learn_w1 got=%0d exp=159", wt(1));
      end
      total++;
      if (upd_valid !== 1'b1) begin
         bad++; $display("FAIL wr_vs_learn_upd got=%b exp=1", upd_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pre_spike = 4'b0001; step(); idle_inputs();
      post_spike = 1'b1;   step(); idle_inputs();   // w0 -> 159, post trace 255
      rst_n = 1'b0; #1;                             // asynchronous: takes effect at once
      total++;
      if (wt(0) !== 8'd128 || upd_valid !== 1'b0) begin
         bad++; $display("FAIL reset_mid_async got_w=%0d got_upd=%b exp_w=128 exp_upd=0", wt(0), upd_valid);
      end
      step();
      rst_n = 1'b1;
      step();
      // Post trace must be 0: a pre spike on synapse 1 causes no depression.
      pre_spike = 4'b0010; step(); idle_inputs();
      total++;
      if (wt(1) !== 8'd128 || upd_valid !== 1'b0) begin
         bad++; $display("FAIL reset_mid_post_trace got_w1=%0d got_upd=%b exp_w1=128 exp_upd=0", wt(1), upd_valid);
      end
      // Pre trace 0 must be 0 (was 255); pre trace 1 is 255 from the spike above.
      post_spike = 1'b1; step(); idle_inputs();
      total++;
      if (wt(0) !== 8'd128) begin
         bad++; $display("FAIL reset_mid_pre_trace got_w0=%0d exp_w0=128", wt(0));
      end
      total++;
      if (wt(1) !== 8'd159) begin
         bad++; $display("FAIL reset_mid_w1 got=%0d exp=159", wt(1));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      learn_en = 1'b1;
      rd_sel   = '0;
      idle_inputs();
      test_reset();
      test_ltp(1'b1, 8'd152, 1'b1);
      test_ltd();
      test_sat_hi();
      test_sat_lo();
      test_coincide();
      test_ltp(1'b0, 8'd128, 1'b0);
      test_decay_floor();
      test_spike_tick();
      test_write_vs_learn();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
